mem_port_arbiter: RTL and testbench

//   Shares one synchronous single-port SRAM between the CPU instruction port and data port.

---
 rtl/mem_port_arbiter.sv | 152 +++++++++++++++
 tb/tb_mem_port_arbiter.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one synchronous single-port SRAM between the CPU
// instruction and data ports. Fetches and loads/stores are serialised, and
// cpu_stall is held until every request of the current group is served.
// Optional build macro: ARB_ROUND_ROBIN_EN. When it is defined, a tie goes to
// the port that did not win last time. When it is undefined, instruction has
// fixed priority over data.
module mem_port_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                instr_read,
    input  logic [ADDR_W-1:0]   instr_addr,
    output logic [DATA_W-1:0]   instr_out,
    output logic                instr_valid,
    input  logic                data_read,
    input  logic [DATA_W/8-1:0] data_write,
    input  logic [ADDR_W-1:0]   data_addr,
    input  logic [DATA_W-1:0]   data_in,
    output logic [DATA_W-1:0]   data_out,
    output logic                data_valid,
    output logic                cpu_stall,
    output logic [ADDR_W-1:0]   sram_addr,
    output logic                sram_read,
    output logic [DATA_W/8-1:0] sram_write,
    output logic [DATA_W-1:0]   sram_di,
    input  logic [DATA_W-1:0]   sram_do
);
    localparam int STRB_W = DATA_W / 8;

    typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

    state_t state, state_nxt;
    logic   i_done, d_done, last_grant;
    logic   gnt_data, gnt_rd;
    logic   d_req, d_wr, i_pend, d_pend, pick_data, grp_release;

    assign d_wr        = |data_write;
    assign d_req       = data_read | d_wr;
    assign i_pend      = instr_read & ~i_done;
    assign d_pend      = d_req & ~d_done;
    assign cpu_stall   = i_pend | d_pend;
    // The CPU advances on any edge where it is not stalled and something completed.
    assign grp_release = ~cpu_stall & (i_done | d_done);
    assign instr_valid = i_done;
    assign data_valid  = d_done;

`ifndef ARB_ROUND_ROBIN_EN
    // Under fixed priority, last_grant is only kept for observability.
    logic unused_last_grant;
    assign unused_last_grant = last_grant;
`endif

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    // Next state and grant choice. The grant is only used in IDLE.
    always_comb begin
        state_nxt = state;
        pick_data = 1'b0;
        if (d_pend && !i_pend) begin
            pick_data = 1'b1;
        end else if (d_pend && i_pend) begin
`ifdef ARB_ROUND_ROBIN_EN
            pick_data = ~last_grant;
`else
            pick_data = 1'b0;
`endif
        end
        case (state)
            IDLE:    if (i_pend || d_pend) state_nxt = ISSUE;
            ISSUE:   state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // SRAM command. It is loaded in IDLE and cleared on the next edge, so it is
    // live for exactly one cycle. A store beats a load on the same port.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sram_addr  <= '0;
            sram_read  <= 1'b0;
            sram_write <= '0;
            sram_di    <= '0;
        end else if (state == IDLE && (i_pend || d_pend)) begin
            if (pick_data) begin
                sram_addr  <= data_addr;
                sram_read  <= ~d_wr;
                sram_write <= data_write;
                sram_di    <= d_wr ? data_in : '0;
            end else begin
                sram_addr  <= instr_addr;
                sram_read  <= 1'b1;
                sram_write <= '0;
                sram_di    <= '0;
            end
        end else begin
            sram_addr  <= '0;
            sram_read  <= 1'b0;
            sram_write <= {STRB_W{1'b0}};
            sram_di    <= '0;
        end
    end

    // Remember the grant so that RESP knows where the read data goes.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            gnt_data <= 1'b0;
            gnt_rd   <= 1'b0;
        end else if (state == IDLE && (i_pend || d_pend)) begin
            gnt_data <= pick_data;
            gnt_rd   <= ~(pick_data & d_wr);
        end
    end

    // Capture read data. sram_do is valid during RESP, one cycle after the read.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            instr_out <= '0;
            data_out  <= '0;
        end else if (state == RESP && gnt_rd) begin
            if (gnt_data) data_out  <= sram_do;
            else          instr_out <= sram_do;
        end
    end

    // Done flags live for the whole group. A completion on the release edge
    // still sets its flag, so a late access is not lost.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            i_done     <= 1'b0;
            d_done     <= 1'b0;
            last_grant <= 1'b0;
        end else begin
            if (grp_release) begin
                i_done <= 1'b0;
                d_done <= 1'b0;
            end
            if (state == RESP) begin
                if (gnt_data) d_done <= 1'b1;
                else          i_done <= 1'b1;
                last_grant <= gnt_data;
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a behavioural synchronous SRAM.
// Timeline convention: edge N is the edge on which IDLE samples a request;
// "after N+k" means sampled 1ns after that edge.
module tb_mem_port_arbiter;
    localparam int AW = 32;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          instr_read = 1'b0;
    logic [AW-1:0] instr_addr = '0;
    logic [DW-1:0] instr_out;
    logic          instr_valid;
    logic          data_read = 1'b0;
    logic [3:0]    data_write = '0;
    logic [AW-1:0] data_addr = '0;
    logic [DW-1:0] data_in = '0;
    logic [DW-1:0] data_out;
    logic          data_valid;
    logic          cpu_stall;
    logic [AW-1:0] sram_addr;
    logic          sram_read;
    logic [3:0]    sram_write;
    logic [DW-1:0] sram_di;
    logic [DW-1:0] sram_do = '0;

    logic [31:0] mem [0:255];
    int errs = 0;
    int checks = 0;

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .rst(rst),
        .instr_read(instr_read), .instr_addr(instr_addr),
        .instr_out(instr_out), .instr_valid(instr_valid),
        .data_read(data_read), .data_write(data_write), .data_addr(data_addr),
        .data_in(data_in), .data_out(data_out), .data_valid(data_valid),
        .cpu_stall(cpu_stall),
        .sram_addr(sram_addr), .sram_read(sram_read), .sram_write(sram_write),
        .sram_di(sram_di), .sram_do(sram_do)
    );

    always #5 clk = ~clk;

    // Behavioural SRAM: word addressed, byte strobes, registered read data.
    always @(posedge clk) begin
        if (sram_read) sram_do <= mem[sram_addr[9:2]];
        for (int b = 0; b < 4; b++)
            if (sram_write[b]) mem[sram_addr[9:2]][8*b +: 8] <= sram_di[8*b +: 8];
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drop_all();
        instr_read = 1'b0;
        data_read  = 1'b0;
        data_write = '0;
    endtask

    logic [31:0] first_addr, second_addr;

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        mem[4]  = 32'h00500093;
        mem[12] = 32'hBADBAD00;
        mem[8]  = 32'h11111111;
        mem[16] = 32'h22222222;
        mem[64] = 32'h12345678;
        mem[65] = 32'h55555555;

        // Reset state
        #12;
        chk("rst_sram_read", sram_read, 0);
        chk("rst_instr_out", instr_out, 0);
        chk("rst_stall", cpu_stall, 0);
        rst = 1'b1;
        tick();

        // 1. Reset asserted while the fetch is in ISSUE
        instr_read = 1'b1; instr_addr = 32'h10;
        tick();
        chk("t1_issue_read", sram_read, 1);
        rst = 1'b0; drop_all();
        #1;
        chk("t1_rst_read", sram_read, 0);
        chk("t1_rst_addr", sram_addr, 0);
        chk("t1_rst_valid", instr_valid, 0);
        chk("t1_rst_stall", cpu_stall, 0);
        #3 rst = 1'b1;
        tick(); tick();
        chk("t1_no_spurious", {sram_read, sram_write}, 0);
        chk("t1_no_valid", instr_valid, 0);

        // 2. Fetch only; the address change after the grant must be ignored
        instr_read = 1'b1; instr_addr = 32'h10;
        #1 chk("t2_stall_req", cpu_stall, 1);
        tick();                                   // after N
        chk("t2_sram_read", sram_read, 1);
        chk("t2_sram_addr", sram_addr, 32'h10);
        instr_addr = 32'h30;
        tick();                                   // after N+1
        chk("t2_read_cleared", sram_read, 0);
        chk("t2_stall_mid", cpu_stall, 1);
        tick();                                   // after N+2
        chk("t2_instr_out", instr_out, 32'h00500093);
        chk("t2_instr_valid", instr_valid, 1);
        chk("t2_stall_fall", cpu_stall, 0);
        drop_all();
        tick();                                   // after N+3
        chk("t2_valid_clear", instr_valid, 0);

        // 3. Fetch and load requested together
        instr_read = 1'b1; instr_addr = 32'h20;
        data_read  = 1'b1; data_addr  = 32'h40;
`ifdef ARB_ROUND_ROBIN_EN
        first_addr = 32'h40; second_addr = 32'h20;
`else
        first_addr = 32'h20; second_addr = 32'h40;
`endif
        tick();                                   // after N
        chk("t3_first_addr", sram_addr, first_addr);
        tick();                                   // after N+1
        tick();                                   // after N+2
`ifdef ARB_ROUND_ROBIN_EN
        chk("t3_first_valid", {instr_valid, data_valid}, 2'b01);
        chk("t3_first_data", data_out, 32'h22222222);
`else
        chk("t3_first_valid", {instr_valid, data_valid}, 2'b10);
        chk("t3_first_data", instr_out, 32'h11111111);
`endif
        chk("t3_stall_n2", cpu_stall, 1);
        tick();                                   // after N+3
        chk("t3_second_addr", sram_addr, second_addr);
        chk("t3_second_read", sram_read, 1);
        tick();                                   // after N+4
        chk("t3_stall_n4", cpu_stall, 1);
        tick();                                   // after N+5
        chk("t3_both_valid", {instr_valid, data_valid}, 2'b11);
        chk("t3_instr_out", instr_out, 32'h11111111);
        chk("t3_data_out", data_out, 32'h22222222);
        chk("t3_stall_done", cpu_stall, 0);
        drop_all();
        tick();
        chk("t3_release", {instr_valid, data_valid}, 2'b00);

        // 4. Partial store
        data_write = 4'b0011; data_addr = 32'h100; data_in = 32'hDEADBEEF;
        tick();                                   // after N
        chk("t4_sram_write", sram_write, 4'b0011);
        chk("t4_sram_di", sram_di, 32'hDEADBEEF);
        chk("t4_sram_read", sram_read, 0);
        tick();                                   // after N+1
        chk("t4_write_once", sram_write, 0);
        tick();                                   // after N+2
        chk("t4_data_valid", data_valid, 1);
        chk("t4_data_out_kept", data_out, 32'h22222222);
        chk("t4_mem", mem[64], 32'h1234BEEF);
        drop_all();
        tick();

        // 6. Read and write together: the write wins
        data_read = 1'b1; data_write = 4'hF; data_addr = 32'h104; data_in = 32'hCAFEF00D;
        tick();
        chk("t6_sram_read", sram_read, 0);
        chk("t6_sram_write", sram_write, 4'hF);
        tick(); tick();
        chk("t6_data_valid", data_valid, 1);
        chk("t6_data_out_kept", data_out, 32'h22222222);
        chk("t6_mem", mem[65], 32'hCAFEF00D);
        drop_all();
        tick();

        // Request dropped mid-access: access completes, then releases on its own
        instr_read = 1'b1; instr_addr = 32'h30;
        tick();
        drop_all();
        tick(); tick();
        chk("drop_valid", instr_valid, 1);
        chk("drop_out", instr_out, 32'hBADBAD00);
        tick();
        chk("drop_release", instr_valid, 0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

    // Hard stop if the stimulus ever stalls.
    initial begin
        #20000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end
endmodule
